// File: rtl/s38417_lane_scan_seq.sv
// s38417_lane_scan_seq
// Slot-register and lane-select stage that feeds the slot-check cone.
// It holds NSLOT three-bit slot registers and drives a one-hot lane select.
// It also presents a registered per-slot view of the selected lane, plus its zero flag.
// A small scan FSM walks lanes 0, 1 and 2 on request.
// At the end of a scan it reports which lanes had every slot bit clear.
module s38417_lane_scan_seq #(
  parameter int NSLOT = 14,
  parameter int LANES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_slot,
  input  logic [LANES-1:0] wr_data,
  input  logic             start,
  output logic [LANES-1:0] lane_sel,
  output logic [NSLOT-1:0] slot_bit,
  output logic             all_clear,
  output logic             busy,
  output logic             done,
  output logic [LANES-1:0] lane_zero
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN0,
    SCAN1,
    SCAN2,
    FIN
  } state_e;

  localparam logic [LANES-1:0] LANE0 = 3'b001;
  localparam logic [LANES-1:0] LANE1 = 3'b010;
  localparam logic [LANES-1:0] LANE2 = 3'b100;

  logic [LANES-1:0] slots_q [NSLOT];
  logic [NSLOT-1:0] slot_bit_d;
  logic [NSLOT-1:0] slot_bit_q;
  logic             all_clear_d;
  logic             all_clear_q;
  state_e           state_q;
  logic [LANES-1:0] lane_sel_q;
  logic             busy_q;
  logic             done_q;
  logic [LANES-1:0] lane_zero_q;

  // Slot storage: an out-of-range index matches no entry, so it is dropped without side effects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) begin
        slots_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (wr_slot == 4'(i)) begin
          slots_q[i] <= wr_data;
        end
      end
    end
  end

  // Pick each slot's bit for the current lane and derive the all-zero flag.
  always_comb begin
    slot_bit_d = '0;
    for (int i = 0; i < NSLOT; i++) begin
      slot_bit_d[i] = |(slots_q[i] & lane_sel_q);
    end
    all_clear_d = ~|slot_bit_d;
  end

  // Register the lane view; this is the one-cycle latency the scan captures rely on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_bit_q  <= '0;
      all_clear_q <= 1'b1;
    end else begin
      slot_bit_q  <= slot_bit_d;
      all_clear_q <= all_clear_d;
    end
  end

  // Scan FSM: each lane is captured one cycle after its view has been registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_sel_q  <= LANE0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lane_zero_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          lane_sel_q <= LANE0;
          if (start) begin
            state_q <= SCAN0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        SCAN0: begin
          state_q    <= SCAN1;
          lane_sel_q <= LANE1;
          busy_q     <= 1'b1;
        end
        SCAN1: begin
          state_q        <= SCAN2;
          lane_sel_q     <= LANE2;
          busy_q         <= 1'b1;
          lane_zero_q[0] <= all_clear_q;
        end
        SCAN2: begin
          state_q        <= FIN;
          lane_sel_q     <= LANE0;
          busy_q         <= 1'b1;
          lane_zero_q[1] <= all_clear_q;
        end
        FIN: begin
          state_q        <= IDLE;
          lane_sel_q     <= LANE0;
          busy_q         <= 1'b0;
          done_q         <= 1'b1;
          lane_zero_q[2] <= all_clear_q;
        end
        default: begin
          state_q    <= IDLE;
          lane_sel_q <= LANE0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign lane_sel  = lane_sel_q;
  assign slot_bit  = slot_bit_q;
  assign all_clear = all_clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lane_zero = lane_zero_q;

endmodule

// File: doc/s38417_lane_scan_seq.md
Name: s38417_lane_scan_seq

Overview:
- Sequential lane-select and slot-register stage feeding the combinational slot-check cone.
- Holds 14 three-bit slot registers and drives the one-hot lane select (lane 0/1/2, matching the g2003/g2006/g2009 roles).
- Presents per-slot selected bits plus a zero flag, registered.
- A scan FSM steps through all three lanes on request and reports which lanes had every slot bit clear.

Parameters:
- NSLOT, 14, number of 3-bit slot registers (index 0..NSLOT-1).
- LANES, 3, bits per slot and one-hot select width; fixed at 3, other values unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- wr_en  input  1  slot write strobe.
- wr_slot  input  4  slot index to write.
- wr_data  input  3  new slot contents; bit k belongs to lane k.
- start  input  1  scan request pulse.
- lane_sel  output  3  one-hot lane select.
- slot_bit  output  NSLOT  bit lane_sel of each slot, registered.
- all_clear  output  1  high when slot_bit is all zero.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse at scan end.
- lane_zero  output  3  per-lane result of the last scan: 1 = every slot clear in that lane.

Behaviour:
- Reset: all state is cleared at a clk edge where rst_n=0.
  - slots=0, lane_sel=3'b001, slot_bit=0, all_clear=1, busy=0, done=0, lane_zero=3'b000, FSM=IDLE.
  - Reset mid-scan aborts the scan; no done pulse is issued.
- Write:
  - wr_en=1 with wr_slot<NSLOT loads wr_data into that slot at the edge.
  - wr_slot>=NSLOT is ignored and leaves no side effects.
  - Writes are accepted in every FSM state.
- slot_bit/all_clear are registered views.
  - At edge t they are computed from the slot contents and lane_sel in effect after edge t-1 (one-cycle latency).
  - A write at edge t shows in slot_bit at edge t+1.
  - all_clear = NOR of the registered slot_bit.
- lane_sel is always exactly one-hot and never 000 or multi-hot.
- FSM states: IDLE, SCAN0, SCAN1, SCAN2, FIN.
  - IDLE: lane_sel=001, busy=0. start=1 -> SCAN0.
  - SCAN0: lane_sel=001, busy=1 -> SCAN1.
  - SCAN1: lane_sel=010 -> SCAN2. Capture lane_zero[0] = all_clear computed for lane 0.
  - SCAN2: lane_sel=100 -> FIN. Capture lane_zero[1].
  - FIN: capture lane_zero[2], done=1 for this one cycle, lane_sel returns to 001 -> IDLE.
  - Each lane's capture occurs one cycle after that lane is selected, which matches the slot_bit latency.
- lane_zero:
  - Updated bit by bit during the scan.
  - During a scan, bits not yet captured keep their old values.
  - Holds its value between scans.
- start while busy or in FIN is ignored; no queuing.
- A write during a scan is seen by any lane whose capture happens at least 2 edges after the write. No other guarantee is given.
- Total scan: start at edge t, done high during the cycle after edge t+4, busy high during cycles t+1..t+4.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> lane_sel=001, slot_bit=0, all_clear=1, lane_zero=000, busy=0.
- Write slot 5 = 3'b010, then wait 2 cycles in IDLE -> slot_bit=0, all_clear=1.
  - Then start -> lane_zero=3'b101 and done pulses exactly once, 5 edges after start.
- Write slot 0=001, slot 13=100, slot 7=010, then start -> lane_zero=000.
  - During SCAN1 the bench sees slot_bit=14'h0001.
  - During SCAN2 the bench sees slot_bit=14'h0080.
- Write with wr_slot=14 and wr_slot=15, data 111 -> no slot changes and slot_bit stays 0.
  - A subsequent scan gives lane_zero=111.
- Assert start on every cycle of a scan -> exactly one done per 5 cycles and busy never drops mid-scan.
  - Apply rst_n=0 in SCAN1 -> IDLE next cycle, no done, lane_zero=000.
- Write slot 3=111 in the same cycle as start, then scan -> lane_zero=000.
  - Write slot 3=000 at the SCAN0 edge -> lane_zero[2:1]=11 and lane_zero[0]=0.
